// File: rtl/fp_mult_acc.sv
// Frame accumulator for cordic_mult_core products: sums len products with W-bit
// saturation and presents each frame sum through a held valid/ack register.
module fp_mult_acc #(
  parameter int N = 16,
  parameter int G = 4,
  parameter int L = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     din,
  input  logic             din_vld,
  input  logic [L-1:0]     len,
  input  logic             clr,
  output logic [N+G-1:0]   sum,
  output logic [N-1:0]     sum_n,
  output logic             sum_vld,
  input  logic             sum_ack,
  output logic             sat,
  output logic             ovr,
  output logic             busy
);
  localparam int W = N + G;
  localparam logic [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};
  localparam logic [N-1:0] MAX_N = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

  logic [L-1:0] cnt_q, cnt_d, flen_q, flen_d;
  logic [W-1:0] acc_q, acc_d, sum_q, sum_d;
  logic [N-1:0] sum_n_q, sum_n_d;
  logic         sum_vld_q, sum_vld_d;
  logic         sat_q, sat_d, sat_i_q, sat_i_d, ovr_q, ovr_d;

  logic [W-1:0] din_ext;
  logic [W:0]   add_full;
  logic         add_ovf;
  logic [W-1:0] acc_new;
  logic         sat_new;
  logic [L-1:0] start_len;
  logic         last;
  logic [W-N:0] acc_hi;
  logic [N-1:0] acc_clamp_n;

  assign din_ext   = {{G{din[N-1]}}, din};
  assign add_full  = {acc_q[W-1], acc_q} + {din_ext[W-1], din_ext};
  assign add_ovf   = add_full[W] ^ add_full[W-1];
  assign start_len = (len == '0) ? L'(1) : len;

  always_comb begin
    acc_new = din_ext;
    sat_new = 1'b0;
    last    = 1'b0;
    if (cnt_q == '0) begin
      last = (start_len == L'(1));
    end else begin
      // Once clamped, later adds start from the clamp value.
      acc_new = add_ovf ? (add_full[W] ? MIN_W : MAX_W) : add_full[W-1:0];
      sat_new = sat_i_q | add_ovf;
      last    = (cnt_q == flen_q - L'(1));
    end
  end

  assign acc_hi      = acc_new[W-1:N-1];
  assign acc_clamp_n = ((&acc_hi) | ~(|acc_hi)) ? acc_new[N-1:0]
                     : (acc_new[W-1] ? MIN_N : MAX_N);

  always_comb begin
    cnt_d     = cnt_q;
    flen_d    = flen_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    sum_n_d   = sum_n_q;
    sum_vld_d = sum_vld_q;
    sat_d     = sat_q;
    sat_i_d   = sat_i_q;
    ovr_d     = ovr_q;
    if (clr) begin
      cnt_d     = '0;
      acc_d     = '0;
      sum_vld_d = 1'b0;
      sat_d     = 1'b0;
      sat_i_d   = 1'b0;
      ovr_d     = 1'b0;
    end else begin
      if (sum_vld_q && sum_ack) sum_vld_d = 1'b0;
      if (din_vld) begin
        if (cnt_q == '0) flen_d = start_len;
        acc_d   = acc_new;
        sat_i_d = sat_new;
        if (last) begin
          cnt_d     = '0;
          sum_d     = acc_new;
          sum_n_d   = acc_clamp_n;
          sat_d     = sat_new;
          sum_vld_d = 1'b1;
          if (sum_vld_q && !sum_ack) ovr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + L'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      flen_q    <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      sum_n_q   <= '0;
      sum_vld_q <= 1'b0;
      sat_q     <= 1'b0;
      sat_i_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      flen_q    <= flen_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      sum_n_q   <= sum_n_d;
      sum_vld_q <= sum_vld_d;
      sat_q     <= sat_d;
      sat_i_q   <= sat_i_d;
      ovr_q     <= ovr_d;
    end
  end

  assign sum     = sum_q;
  assign sum_n   = sum_n_q;
  assign sum_vld = sum_vld_q;
  assign sat     = sat_q;
  assign ovr     = ovr_q;
  assign busy    = (cnt_q != '0);
endmodule

// File: tb/tb_fp_mult_acc.sv
// Randomized scoreboard bench for fp_mult_acc: a frame-level model queues the
// expected output; a negedge monitor checks it on every accepted handshake.
module tb_fp_mult_acc;
  localparam int N = 16, G = 4, L = 8, W = 20;
  localparam int MAXW = 524287, MINW = -524288;
  localparam int MAXN = 32767, MINN = -32768;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] din = '0;
  logic         din_vld = 1'b0;
  logic [L-1:0] len = '0;
  logic         clr = 1'b0;
  logic [W-1:0] sum;
  logic [N-1:0] sum_n;
  logic         sum_vld;
  logic         sum_ack = 1'b0;
  logic         sat, ovr, busy;

  fp_mult_acc #(.N(N), .G(G), .L(L)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .len(len), .clr(clr),
    .sum(sum), .sum_n(sum_n), .sum_vld(sum_vld), .sum_ack(sum_ack),
    .sat(sat), .ovr(ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic [N-1:0] sn;
    bit           st;
  } exp_t;

  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  exp_t outq[$];
  int   frame[$];
  int   flen = 1;
  bit   exp_vld = 1'b0;
  bit   exp_ovr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    outq.delete();
    frame.delete();
    exp_vld = 1'b0;
    exp_ovr = 1'b0;
  endtask

  // Frame-level behaviour: collect products, fold them with W-bit clamping at frame end.
  task automatic model_step(input bit v, input logic [N-1:0] d, input logic [L-1:0] l,
                            input bit c, input bit a);
    int   acc;
    bit   st;
    exp_t e;
    if (c) begin
      frame.delete();
      outq.delete();
      exp_vld = 1'b0;
      exp_ovr = 1'b0;
      return;
    end
    if (v) begin
      if (frame.size() == 0) flen = (l == 0) ? 1 : int'(l);
      frame.push_back(int'($signed(d)));
    end
    if (v && frame.size() == flen) begin
      acc = frame[0];
      st  = 1'b0;
      for (int i = 1; i < frame.size(); i++) begin
        acc += frame[i];
        if (acc > MAXW) begin acc = MAXW; st = 1'b1; end
        if (acc < MINW) begin acc = MINW; st = 1'b1; end
      end
      e.s  = acc[W-1:0];
      e.sn = (acc > MAXN) ? 16'h7FFF : (acc < MINN) ? 16'h8000 : acc[N-1:0];
      e.st = st;
      if (exp_vld && !a) begin
        exp_ovr = 1'b1;
        outq.delete();
      end
      outq.push_back(e);
      exp_vld = 1'b1;
      frame.delete();
    end else if (exp_vld && a) begin
      exp_vld = 1'b0;
    end
  endtask

  task automatic cyc(input bit v, input logic [N-1:0] d, input logic [L-1:0] l,
                     input bit c, input bit a);
    din_vld = v; din = d; len = l; clr = c; sum_ack = a;
    @(posedge clk);
    #1;
    model_step(v, d, l, c, a);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("sum_vld", 32'(sum_vld), 32'(exp_vld));
      chk("ovr", 32'(ovr), 32'(exp_ovr));
      chk("busy", 32'(busy), 32'(frame.size() != 0));
      if (sum_vld && sum_ack) begin
        if (outq.size() == 0) begin
          chk("accept_without_expected", 32'(1), 32'(0));
        end else begin
          chk("sum", 32'(sum), 32'(outq[0].s));
          chk("sum_n", 32'(sum_n), 32'(outq[0].sn));
          chk("sat", 32'(sat), 32'(outq[0].st));
          void'(outq.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sum", 32'(sum), 32'(0));
    chk("reset_sum_vld", 32'(sum_vld), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    rst = 1'b1;
    mon_en = 1'b1;

    // Basic 3-product frame
    cyc(1, 16'h0100, 3, 0, 0);
    cyc(1, 16'h0200, 3, 0, 0);
    cyc(1, 16'hFF00, 3, 0, 0);
    chk("t1_sum", 32'(sum), 32'h00200);
    chk("t1_sum_n", 32'(sum_n), 32'h0200);
    cyc(0, 0, 3, 0, 1);

    // Large positive frames that hit the W-bit clamp
    for (int i = 0; i < 20; i++) cyc(1, 16'h7FFF, 20, 0, 0);
    cyc(0, 0, 20, 0, 1);
    for (int i = 0; i < 21; i++) cyc(1, 16'h7FFF, 21, 0, 0);
    chk("t2_sum", 32'(sum), 32'h7FFFF);
    chk("t2_sat", 32'(sat), 32'(1));
    cyc(0, 0, 21, 0, 1);

    // Overwrite without ack sets sticky ovr
    cyc(1, 16'h8000, 1, 0, 0);
    cyc(1, 16'h0001, 1, 0, 0);
    chk("t3_sum_n", 32'(sum_n), 32'h0001);
    chk("t3_ovr", 32'(ovr), 32'(1));
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);

    // clr drops the partial frame and the simultaneous strobe
    cyc(1, 16'h0010, 2, 0, 0);
    cyc(1, 16'h0020, 2, 1, 0);
    cyc(1, 16'h0003, 2, 0, 0);
    cyc(1, 16'h0003, 2, 0, 0);
    chk("t4_sum", 32'(sum), 32'h00006);
    cyc(0, 0, 2, 0, 1);

    // Asynchronous reset mid-frame
    cyc(1, 16'h0005, 4, 0, 0);
    cyc(1, 16'h0005, 4, 0, 0);
    din_vld = 1'b0;
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_sum", 32'(sum), 32'(0));
    chk("arst_sum_n", 32'(sum_n), 32'(0));
    chk("arst_ovr_sat_vld", 32'({ovr, sat, sum_vld}), 32'(0));
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1, 16'h0001, 4, 0, 0);
    chk("t5_sum", 32'(sum), 32'h00004);
    cyc(0, 0, 4, 0, 1);

    // len=0: every strobe is a frame, full rate with ack tied high
    for (int i = 0; i < 8; i++) cyc(1, 16'(i * 37 - 100), 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] d;
      logic [L-1:0] l;
      d = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000)
                                      : 16'($urandom);
      l = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(20, 40)) : 8'($urandom_range(0, 5));
      cyc($urandom_range(0, 1) == 1, d, l, $urandom_range(0, 49) == 0,
          $urandom_range(0, 2) != 0);
    end
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("drained", 32'(outq.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
